// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
// Contents: bcd_digit_t, BCD_MAX / BCD_CORR digit constants, bcd_state_t FSM encoding.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bcd_state_t;

endpackage

// File: rtl/bcd_addsub_serial_if.sv
// Request/response bundle for bcd_addsub_serial.
// Request side : in_valid/in_ready handshake, operands in_a/in_b (packed BCD), in_sub, in_cin.
// Response side: out_valid/out_ready handshake, out_sum (packed BCD), out_cout, out_err.
// master = producer/consumer side, slave = the arithmetic block.
interface bcd_addsub_serial_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = 4 * DIGITS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_err;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_err
    );

endinterface

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal (>9) correction.
// Ports: a, b (BCD digits), cin -> digit (corrected BCD digit), cout (decimal carry).
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t digit,
    output logic       cout
);

    logic [4:0] s;

    // 5-bit binary sum, then add 6 to skip the unused codes when it exceeds 9
    assign s     = 5'(a) + 5'(b) + 5'(cin);
    assign cout  = (s > 5'(BCD_MAX));
    assign digit = cout ? 4'(s + 5'(BCD_CORR)) : s[3:0];

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial N-digit BCD adder/subtractor, one digit per clock, LSD first.
// Ports: clk, rst_n (async active-low), bus (bcd_addsub_serial_if.slave).
// Subtraction adds the nines complement of B with carry-in ~in_cin; the result is
// left in ten's complement form when out_cout=0 (borrow).
// Optional build macro BCD_DIGIT_CHECK_EN: flags any input digit >9 on out_err.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    bcd_addsub_serial_if.slave   bus
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    bcd_state_t    state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          sub_q;
    logic          out_valid_q;
    logic [W-1:0]  out_sum_q;
    logic          out_cout_q;

    bcd_digit_t    a_i;
    bcd_digit_t    b_i;
    bcd_digit_t    b_eff;
    bcd_digit_t    digit;
    logic          dcout;

    // Current digit pair and nines-complement mux in front of the shared adder
    assign a_i   = a_sh[3:0];
    assign b_i   = b_sh[3:0];
    assign b_eff = sub_q ? 4'(BCD_MAX - b_i) : b_i;

    bcd_digit_adder u_digit_adder (
        .a     (a_i),
        .b     (b_eff),
        .cin   (carry),
        .digit (digit),
        .cout  (dcout)
    );

    // Result digit enters at the MSB end; written as shifts so DIGITS=1 needs no special case
    assign acc_next = (acc >> 4) | (W'(digit) << (W - 4));

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            acc         <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
            sub_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.in_a;
                        b_sh  <= bus.in_b;
                        sub_q <= bus.in_sub;
                        carry <= bus.in_sub ? ~bus.in_cin : bus.in_cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    acc   <= acc_next;
                    carry <= dcout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(DIGITS - 1)) begin
                        state       <= ST_DONE;
                        out_valid_q <= 1'b1;
                        out_sum_q   <= acc_next;
                        out_cout_q  <= dcout;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q;

    // Sticky invalid-digit flag, cleared when a new request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == ST_IDLE && bus.in_valid) begin
            err_q <= 1'b0;
        end else if (state == ST_RUN && (a_i > BCD_MAX || b_i > BCD_MAX)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.out_err = err_q;
`else
    assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Directed self-checking bench for bcd_addsub_serial (DIGITS=4) with a result scoreboard.
module tb_bcd_addsub_serial;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

`ifdef BCD_DIGIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    exp_t sb[$];

    bcd_addsub_serial_if #(.DIGITS(DIGITS)) bus ();

    bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal reference: plain integer arithmetic on the operand values
    function automatic exp_t model(input int a, input int b, input bit sub, input bit cin);
        exp_t e;
        int   v;
        e.err = 1'b0;
        if (sub) begin
            v      = a - b - int'(cin);
            e.cout = (v >= 0);
            if (v < 0) v = v + 10000;
        end else begin
            v      = a + b + int'(cin);
            e.cout = (v >= 10000);
            v      = v % 10000;
        end
        e.sum = to_bcd(v);
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub, input bit cin,
                        input exp_t e);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_dec(input int a, input int b, input bit sub, input bit cin);
        send(to_bcd(a), to_bcd(b), sub, cin, model(a, b, sub, cin));
    endtask

    // Waits for the result, checks latency and payload, holds backpressure, then handshakes
    task automatic collect(input string tag, input int exp_lat, input int hold);
        int   lat;
        exp_t e;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, ".sum"},  32'(bus.out_sum),  32'(e.sum));
        check({tag, ".cout"}, 32'(bus.out_cout), 32'(e.cout));
        check({tag, ".err"},  32'(bus.out_err),  32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".hold_sum"},   32'(bus.out_sum),   32'(e.sum));
            check({tag, ".hold_ready"}, 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".post_ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ra;
        int rb;
        bit rs;
        bit rc;
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready",  32'(bus.in_ready),  32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_sum",   32'(bus.out_sum),   32'd0);
        check("rst.out_cout",  32'(bus.out_cout),  32'd0);
        check("rst.out_err",   32'(bus.out_err),   32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add, carry propagation through all digits, carry-in
        send_dec(1234, 5678, 1'b0, 1'b0); collect("add_1234_5678", 4, 0);
        send_dec(9999, 1,    1'b0, 1'b0); collect("add_9999_0001", 4, 0);
        send_dec(9999, 0,    1'b0, 1'b1); collect("add_9999_cin",  4, 0);

        // Subtract with and without borrow, and with borrow-in
        send_dec(5000, 1234, 1'b1, 1'b0); collect("sub_5000_1234", 4, 0);
        send_dec(1,    2,    1'b1, 1'b0); collect("sub_0001_0002", 4, 0);
        send_dec(5000, 1234, 1'b1, 1'b1); collect("sub_borrow_in", 4, 0);

        // Backpressure; an in_valid pulse during RUN must be ignored
        send_dec(4321, 1111, 1'b0, 1'b0);
        bus.in_a     = to_bcd(9999);
        bus.in_b     = to_bcd(9999);
        bus.in_valid = 1'b1;
        check("bp.in_ready_run", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        collect("backpressure", 3, 5);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("bp.idle_valid", 32'(bus.out_valid), 32'd0);
            check("bp.idle_ready", 32'(bus.in_ready),  32'd1);
        end

        // Reset during RUN digit 2 discards the partial result
        send_dec(1111, 2222, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst.in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.out_sum",   32'(bus.out_sum),   32'd0);
        check("midrst.out_cout",  32'(bus.out_cout),  32'd0);
        check("midrst.out_err",   32'(bus.out_err),   32'd0);
        void'(sb.pop_back());
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_dec(1234, 5678, 1'b0, 1'b0); collect("after_reset", 4, 0);

        // Invalid digit 0xA in A: result still deterministic, flag only with the check build
        send(16'h12A4, 16'h0000, 1'b0, 1'b0, '{sum: 16'h1304, cout: 1'b0, err: CHK});
        collect("bad_digit", 4, 0);
        send_dec(1234, 0, 1'b0, 1'b0); collect("good_after_bad", 4, 0);

        // A few random decimal operations
        for (int i = 0; i < 4; i++) begin
            ra = int'($urandom_range(0, 9999));
            rb = int'($urandom_range(0, 9999));
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            send_dec(ra, rb, rs, rc);
            collect("random", 4, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
